// File: rtl/conv_pool_write_controller_pkg.sv
// Shared parameters, state encoding and helpers for the conv-layer pooling write controller.
// The optional ReLU stage is enabled by defining CONV_WR_RELU_EN and is implemented in the top module.
package conv_wr_pkg;

  localparam int DW        = 16;
  localparam int OW        = 6;
  localparam int OH        = 8;
  localparam int CH        = 112;
  localparam int AW        = 13;
  localparam int PLANE     = OW * OH;
  localparam int LAST_ADDR = CH * PLANE - 1;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Returns the larger of two two's-complement values.
  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/conv_pool_write_controller_if.sv
// Conv-result input stream and feature-RAM write port of the pooling write controller.
// The master side (MAC datapath or bench) drives samples; the slave side is the controller.
interface conv_pool_write_controller_if;
  import conv_wr_pkg::*;

  logic                 iVALID;
  logic signed [DW-1:0] iDATA;
  logic                 oWR_EN;
  logic [AW-1:0]        oWR_ADDR;
  logic [DW-1:0]        oWR_DATA;
  logic                 oWR_DONE;

  modport master (
    output iVALID, iDATA,
    input  oWR_EN, oWR_ADDR, oWR_DATA, oWR_DONE
  );

  modport slave (
    input  iVALID, iDATA,
    output oWR_EN, oWR_ADDR, oWR_DATA, oWR_DONE
  );

endinterface

// File: rtl/conv_pool_write_controller_wrap_counter.sv
// Modulo-(MAX+1) counter with enable, synchronous reset/clear and a wrap pulse.
// wrap is combinational so counters can be chained within the same cycle.
module wrap_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (en) begin
      if (cnt_q == W'(MAX)) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/conv_pool_write_controller.sv
// Reduces each group of four conv results to a signed max and writes it channel-major into the next layer RAM.
// Define CONV_WR_RELU_EN to clamp negative pooled values to zero before writing.
module conv_pool_write_controller
  import conv_wr_pkg::*;
(
  input logic                          iCLK,
  input logic                          iRST,
  input logic                          iCLR,
  conv_pool_write_controller_if.slave  bus
);

  localparam int PW = 2;
  localparam int CW = $clog2(CH);
  localparam int IW = $clog2(OW);
  localparam int JW = $clog2(OH);

  state_t               state_q, state_d;
  logic signed [DW-1:0] max_q, max_d;
  logic [AW-1:0]        base_q, base_d;
  logic [AW-1:0]        row_q, row_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [DW-1:0]        wr_data_q, wr_data_d;

  logic                 clr_all;
  logic                 accept;
  logic signed [DW-1:0] pooled;
  logic [PW-1:0]        p_cnt;
  logic [CW-1:0]        c_cnt;
  logic [IW-1:0]        i_cnt;
  logic [JW-1:0]        j_cnt;
  logic                 p_wrap, c_wrap, i_wrap, j_wrap;

  assign clr_all = iRST | iCLR;
  // Reset and clear win over a coincident sample, and DONE freezes everything.
  assign accept  = bus.iVALID & (state_q == RUN) & ~clr_all;

  wrap_counter #(.MAX(3),      .W(PW)) u_p_cnt (.clk(iCLK), .rst(iRST), .clr(iCLR), .en(accept), .cnt(p_cnt), .wrap(p_wrap));
  wrap_counter #(.MAX(CH - 1), .W(CW)) u_c_cnt (.clk(iCLK), .rst(iRST), .clr(iCLR), .en(p_wrap), .cnt(c_cnt), .wrap(c_wrap));
  wrap_counter #(.MAX(OW - 1), .W(IW)) u_i_cnt (.clk(iCLK), .rst(iRST), .clr(iCLR), .en(c_wrap), .cnt(i_cnt), .wrap(i_wrap));
  wrap_counter #(.MAX(OH - 1), .W(JW)) u_j_cnt (.clk(iCLK), .rst(iRST), .clr(iCLR), .en(i_wrap), .cnt(j_cnt), .wrap(j_wrap));

  assign pooled = smax(max_q, bus.iDATA);

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    base_d    = base_q;
    row_d     = row_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (accept) begin
      max_d = (p_cnt == '0) ? bus.iDATA : pooled;

      if (p_wrap) begin
        wr_en_d   = 1'b1;
        // base tracks c*PLANE, row tracks j*OW; the column is the live counter.
        wr_addr_d = base_q + row_q + AW'(i_cnt);
`ifdef CONV_WR_RELU_EN
        wr_data_d = pooled[DW-1] ? '0 : pooled;
`else
        wr_data_d = pooled;
`endif
        base_d    = (c_cnt == CW'(CH - 1)) ? '0 : base_q + AW'(PLANE);
        if (j_wrap) state_d = DONE;
      end

      if (i_wrap) row_d = (j_cnt == JW'(OH - 1)) ? '0 : row_q + AW'(OW);
    end
  end

  always_ff @(posedge iCLK) begin
    if (clr_all) begin
      state_q   <= RUN;
      max_q     <= '0;
      base_q    <= '0;
      row_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      base_q    <= base_d;
      row_q     <= row_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.oWR_EN   = wr_en_q;
  assign bus.oWR_ADDR = wr_addr_q;
  assign bus.oWR_DATA = wr_data_q;
  assign bus.oWR_DONE = (state_q == DONE);

endmodule

// File: tb/tb_conv_pool_write_controller.sv
// Directed bench for conv_pool_write_controller: single groups, gaps, mid-group clear and a full map pass.
// Expected pooled data follows CONV_WR_RELU_EN when it is defined for the build.
module tb_conv_pool_write_controller;
  import conv_wr_pkg::*;

  logic iCLK = 1'b0;
  logic iRST;
  logic iCLR;

  conv_pool_write_controller_if bus ();

  conv_pool_write_controller dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .iCLR (iCLR),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then look at the registered outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic [DW-1:0] d);
    bus.iVALID = v;
    bus.iDATA  = d;
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_out(input logic signed [DW-1:0] m);
`ifdef CONV_WR_RELU_EN
    return (m < 0) ? '0 : m;
`else
    return m;
`endif
  endfunction

  task automatic check_write(input string tag, input int addr, input logic [DW-1:0] data);
    check({tag, "_en"},   32'(bus.oWR_EN), 32'd1);
    check({tag, "_addr"}, 32'(bus.oWR_ADDR), addr);
    check({tag, "_data"}, 32'(bus.oWR_DATA), 32'(data));
  endtask

  logic signed [DW-1:0] v;
  logic signed [DW-1:0] mx;
  logic                 last;

  initial begin
    bus.iVALID = 1'b0;
    bus.iDATA  = '0;
    iCLR       = 1'b0;
    iRST       = 1'b1;
    step(0, 0);
    step(0, 0);
    iRST = 1'b0;

    check("rst_en",   32'(bus.oWR_EN),   32'd0);
    check("rst_addr", 32'(bus.oWR_ADDR), 32'd0);
    check("rst_data", 32'(bus.oWR_DATA), 32'd0);
    check("rst_done", 32'(bus.oWR_DONE), 32'd0);

    // Group 1 (c=0,i=0,j=0): max 7 at address 0.
    step(1, -16'sd5);  check("g1_p0_en", 32'(bus.oWR_EN), 32'd0);
    step(1, 16'sd7);   check("g1_p1_en", 32'(bus.oWR_EN), 32'd0);
    step(1, 16'sd3);   check("g1_p2_en", 32'(bus.oWR_EN), 32'd0);
    step(1, -16'sd1);  check_write("g1", 0, 16'd7);
    step(0, 0);
    check("g1_idle_en",   32'(bus.oWR_EN),   32'd0);
    check("g1_hold_addr", 32'(bus.oWR_ADDR), 32'd0);
    check("g1_hold_data", 32'(bus.oWR_DATA), 32'd7);

    // Group 2 (c=1): all negative, max -2 (or 0 with ReLU) at address 48.
    step(1, -16'sd9);
    step(1, -16'sd2);
    step(1, -16'sd30);
    step(1, -16'sd4);  check_write("g2_neg", 48, exp_out(-16'sd2));

    // Group 3 (c=2) with a 10-cycle gap in the middle.
    step(1, 16'sd20);
    step(1, -16'sd8);
    for (int k = 0; k < 10; k++) begin
      step(0, 16'sd999);
      check("gap_en", 32'(bus.oWR_EN), 32'd0);
    end
    step(1, -16'sd3);  check("gap_p2_en", 32'(bus.oWR_EN), 32'd0);
    step(1, 16'sd4);   check_write("gap", 96, 16'd20);

    // Clear after two samples of a new group; the sample coincident with iCLR is dropped.
    step(1, 16'sd100);
    step(1, 16'sd200);
    iCLR = 1'b1;
    step(1, 16'sd999);
    iCLR = 1'b0;
    check("clr_en",   32'(bus.oWR_EN),   32'd0);
    check("clr_addr", 32'(bus.oWR_ADDR), 32'd0);
    check("clr_data", 32'(bus.oWR_DATA), 32'd0);
    step(1, 16'sd11);  check("clr_p0_en", 32'(bus.oWR_EN), 32'd0);
    step(1, -16'sd4);  check("clr_p1_en", 32'(bus.oWR_EN), 32'd0);
    step(1, 16'sd12);  check("clr_p2_en", 32'(bus.oWR_EN), 32'd0);
    step(1, 16'sd3);   check_write("clr_grp", 0, 16'd12);
    step(0, 0);        check("clr_after_en", 32'(bus.oWR_EN), 32'd0);

    // iRST wins over iCLR and both restart the map.
    iRST = 1'b1;
    iCLR = 1'b1;
    step(1, 16'sd5);
    iRST = 1'b0;
    iCLR = 1'b0;
    check("rst2_data", 32'(bus.oWR_DATA), 32'd0);

    // Full-rate pass over the whole output map with random data.
    for (int j = 0; j < OH; j++) begin
      for (int i = 0; i < OW; i++) begin
        for (int c = 0; c < CH; c++) begin
          for (int p = 0; p < 4; p++) begin
            v  = DW'($urandom);
            mx = (p == 0 || v > mx) ? v : mx;
            step(1, v);
            if (p == 3) begin
              last = (j == OH - 1) && (i == OW - 1) && (c == CH - 1);
              check_write("pass", c * PLANE + j * OW + i, exp_out(mx));
              check("pass_done", 32'(bus.oWR_DONE), 32'(last));
            end else begin
              check("pass_noen", 32'(bus.oWR_EN), 32'd0);
            end
          end
        end
      end
    end
    check("last_addr", 32'(bus.oWR_ADDR), LAST_ADDR);

    // DONE ignores further samples and holds until cleared.
    for (int k = 0; k < 8; k++) begin
      step(1, 16'sd50);
      check("done_noen",  32'(bus.oWR_EN),   32'd0);
      check("done_level", 32'(bus.oWR_DONE), 32'd1);
    end
    check("done_hold_addr", 32'(bus.oWR_ADDR), LAST_ADDR);

    iCLR = 1'b1;
    step(0, 0);
    iCLR = 1'b0;
    check("clr_done", 32'(bus.oWR_DONE), 32'd0);
    check("clr_done_en", 32'(bus.oWR_EN), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
